timestamp_capture: RTL and testbench

TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

---
 rtl/timestamp_capture_pkg.sv | 15 +
 rtl/ts_fifo.sv | 76 +++++++
 rtl/timestamp_capture.sv | 94 +++++++++
 tb/tb_timestamp_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_capture_pkg.sv
// Shared defaults and types for the timestamp capture block.
// Optional synchroniser selected with TIMESTAMP_CAPTURE_SYNC_EN (see timestamp_capture.sv).
package timestamp_capture_pkg;

    localparam int unsigned TS_W_DEFAULT  = 51;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef logic [TS_W_DEFAULT-1:0] ts_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// Timestamp storage: power-of-two circular buffer with occupancy count and synchronous clear.
// Read data is forced to zero while empty so the head output is defined after reset/clear.
module ts_fifo
    import timestamp_capture_pkg::*;
#(
    parameter int unsigned WIDTH = TS_W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ts_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == FullLevel);
        do_pop  = pop & ~empty;
        // A full buffer still takes a write when the head leaves in the same cycle.
        do_push = push & (~full | do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: rtl/timestamp_capture.sv
// Captures count_in on each rising edge of event_in into a small FIFO with sticky overflow.
// Define TIMESTAMP_CAPTURE_SYNC_EN to add a two-flop synchroniser ahead of edge detection.
module timestamp_capture
    import timestamp_capture_pkg::*;
#(
    parameter int unsigned TS_W  = TS_W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TS_W-1:0]          count_in,
    input  logic                     event_in,
    input  logic                     clr,
    output logic [TS_W-1:0]          ts_data,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    logic ev_s;
    logic ev_prev_q;
    logic edge_det;
    logic push_req;
    logic push;
    logic pop;
    logic drop;
    logic full;
    logic empty;
    logic overflow_q;

`ifdef TIMESTAMP_CAPTURE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], event_in};
        end
    end

    assign ev_s = sync_q[1];
`else
    assign ev_s = event_in;
`endif

    // Keeps tracking the line during clr so a held-high event is not re-detected afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_prev_q <= 1'b0;
        end else begin
            ev_prev_q <= ev_s;
        end
    end

    always_comb begin
        edge_det = ev_s & ~ev_prev_q;
        pop      = ts_ready & ~empty;
        push_req = edge_det & ~clr;
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (clr) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .push_data (count_in),
        .pop       (pop),
        .pop_data  (ts_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign ts_valid = ~empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_timestamp_capture.sv
// Scoreboard bench for timestamp_capture: directed scenarios then randomized traffic.
// Honours TIMESTAMP_CAPTURE_SYNC_EN for the extra detection latency.
module tb_timestamp_capture;
    import timestamp_capture_pkg::*;

    localparam int unsigned DEPTH = DEPTH_DEFAULT;
`ifdef TIMESTAMP_CAPTURE_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    ts_t                      count_in = '0;
    logic                     event_in = 1'b0;
    logic                     clr = 1'b0;
    ts_t                      ts_data;
    logic                     ts_valid;
    logic                     ts_ready = 1'b0;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;

    timestamp_capture #(
        .TS_W  (TS_W_DEFAULT),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .event_in (event_in),
        .clr      (clr),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: expected FIFO contents, occupancy, overflow, event history.
    ts_t exp_q[$];
    bit  hist_q[$];
    bit  prev_m;
    int  mlevel;
    bit  movf;
    bit  flush_pend;
    ts_t cnt;
    ts_t max_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hist_q.delete();
        for (int i = 0; i < int'(LAT); i++) hist_q.push_back(1'b0);
        prev_m     = 1'b0;
        mlevel     = 0;
        movf       = 1'b0;
        flush_pend = 1'b0;
    endtask

    // One clock: drive inputs, predict the edge's effect, then check state after the edge.
    task automatic step(input logic ev, input ts_t c, input logic rdy, input logic cl);
        bit det;
        bit edge_m;
        bit pop_m;
        if (flush_pend) begin
            exp_q.delete();
            flush_pend = 1'b0;
        end
        event_in = ev;
        count_in = c;
        ts_ready = rdy;
        clr      = cl;
        hist_q.push_back(ev);
        det    = hist_q.pop_front();
        edge_m = det && !prev_m;
        prev_m = det;
        pop_m  = rdy && (mlevel > 0);
        if (cl) begin
            mlevel     = 0;
            movf       = 1'b0;
            flush_pend = 1'b1;
        end else begin
            if (edge_m) begin
                if (mlevel < int'(DEPTH) || pop_m) begin
                    exp_q.push_back(c);
                    mlevel++;
                end else begin
                    movf = 1'b1;
                end
            end
            if (pop_m) mlevel--;
        end
        @(posedge clk);
        #1;
        check("level", 64'(level), 64'(mlevel));
        check("ts_valid", 64'(ts_valid), 64'(mlevel != 0));
        check("overflow", 64'(overflow), 64'(movf));
    endtask

    task automatic do_reset(input logic ev_hold);
        event_in = ev_hold;
        rst      = 1'b1;
        #1;
        check("rst_level", 64'(level), 64'd0);
        check("rst_valid", 64'(ts_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_ts_data", 64'(ts_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        for (int i = 0; i < int'(DEPTH) + 2; i++) step(1'b0, cnt, 1'b1, 1'b0);
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every accepted head entry must match the oldest expected timestamp.
    always @(negedge clk) begin
        if (!rst && ts_valid && ts_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 64'(ts_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("ts_data", 64'(ts_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        max_cnt = '1;
        cnt     = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Single pulse captured at count 100 and drained immediately.
        step(1'b0, 99, 1'b1, 1'b0);
        step(1'b1, 100, 1'b1, 1'b0);
        step(1'b0, 101, 1'b1, 1'b0);
        drain();

        // Five edges with consumer stalled: four stored, fifth dropped.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, ts_t'(i * 10), 1'b0, 1'b0);
            step(1'b0, ts_t'(i * 10 + 1), 1'b0, 1'b0);
        end
        check("full_level", 64'(level), 64'(DEPTH));
        check("full_overflow", 64'(overflow), 64'd1);
        drain();
        step(1'b0, cnt, 1'b0, 1'b1);

        // Full buffer, simultaneous pop and new edge: no drop, 60 goes to the tail.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, ts_t'(i * 10), 1'b0, 1'b0);
            step(1'b0, 0, 1'b0, 1'b0);
        end
        step(1'b1, 60, 1'b1, 1'b0);
        check("simul_overflow", 64'(overflow), 64'd0);
        drain();

        // Held-high event gives one entry.
        for (int i = 0; i < 20; i++) step(1'b1, ts_t'(200 + i), 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        drain();

        // clr with a coincident edge discards everything.
        step(1'b1, 300, 1'b0, 1'b0);
        step(1'b0, 301, 1'b0, 1'b0);
        step(1'b1, 302, 1'b0, 1'b0);
        step(1'b0, 303, 1'b0, 1'b0);
        step(1'b1, 304, 1'b0, 1'b1);
        step(1'b0, 305, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream with the event held high through release.
        step(1'b1, 400, 1'b0, 1'b0);
        step(1'b0, 401, 1'b0, 1'b0);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, ts_t'(500 + i), 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        drain();

        // Counter wrap captured verbatim.
        step(1'b1, max_cnt, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2, 1'b0, 1'b0);
        drain();

        // Randomized traffic with free-running count, occasional jumps, clears and resets.
        cnt = ts_t'($urandom);
        for (int seg = 0; seg < 6; seg++) begin
            int rdy_bias = $urandom_range(1, 6);
            for (int i = 0; i < 500; i++) begin
                logic ev_r;
                logic rdy_r;
                logic clr_r;
                cnt = cnt + 1'b1;
                if ($urandom_range(0, 150) == 0) cnt = max_cnt - ts_t'($urandom_range(0, 4));
                ev_r  = ($urandom_range(0, 2) == 0);
                rdy_r = ($urandom_range(0, 7) < rdy_bias);
                clr_r = ($urandom_range(0, 80) == 0);
                step(ev_r, cnt, rdy_r, clr_r);
            end
            do_reset(logic'($urandom_range(0, 1)));
        end
        step(1'b0, cnt, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
